// File: rtl/sodor_arb_pkg.sv
// Shared types and widths for the sodor data-memory arbiter.
package sodor_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned STREAK_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_DBG
    } arb_owner_e;

endpackage

// File: rtl/sodor_arb_grant.sv
// Priority decision between core and debug requesters, with the
// debug-streak counter that bounds how long the core can be starved.
module sodor_arb_grant
    import sodor_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic core_req_valid,
    input  logic dbg_req_valid,
    output logic grant_core,
    output logic grant_dbg
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_nxt;
    logic                at_limit;

    // Grant decision and next streak value.
    always_comb begin
        at_limit   = (streak == LIMIT);
        grant_core = arb_en && core_req_valid && (!dbg_req_valid || at_limit);
        grant_dbg  = arb_en && dbg_req_valid && !(core_req_valid && at_limit);
        streak_nxt = streak;
        if (grant_core) begin
            streak_nxt = '0;
        end else if (grant_dbg) begin
            if (!core_req_valid) begin
                streak_nxt = '0;
            end else if (!at_limit) begin
                streak_nxt = streak + 1'b1;
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else begin
            streak <= streak_nxt;
        end
    end

endmodule

// File: rtl/sodor_dmem_arbiter.sv
// Two-requester arbiter in front of the sodor data-memory port.
// Each access runs IDLE -> ISSUE -> RESP so mem_we is high for one edge.
// Optional macro SODOR_ARB_PERF_EN adds grant/stall performance counters.
module sodor_dmem_arbiter
    import sodor_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned DATA_W     = ARB_DATA_W,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_wdata,
    input  logic              core_req_we,
    output logic              core_resp_valid,
    output logic [DATA_W-1:0] core_resp_data,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    input  logic              dbg_req_we,
    output logic              dbg_resp_valid,
    output logic [DATA_W-1:0] dbg_resp_data,
`ifdef SODOR_ARB_PERF_EN
    output logic [31:0]       perf_core_grants,
    output logic [31:0]       perf_dbg_grants,
    output logic [31:0]       perf_core_stall,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state;
    arb_state_e state_nxt;
    arb_owner_e owner;
    logic       op_we;
    logic       arb_en;
    logic       grant_core;
    logic       grant_dbg;

    // Arbitration is only open while idle.
    always_comb begin
        arb_en = (state == ARB_IDLE);
    end

    sodor_arb_grant #(
        .MAX_STREAK (MAX_STREAK)
    ) u_grant (
        .clk            (clk),
        .rst_n          (rst_n),
        .arb_en         (arb_en),
        .core_req_valid (core_req_valid),
        .dbg_req_valid  (dbg_req_valid),
        .grant_core     (grant_core),
        .grant_dbg      (grant_dbg)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake readies and response strobes.
    always_comb begin
        state_nxt       = state;
        core_req_ready  = grant_core;
        dbg_req_ready   = grant_dbg;
        core_resp_valid = 1'b0;
        dbg_resp_valid  = 1'b0;
        core_resp_data  = '0;
        dbg_resp_data   = '0;
        case (state)
            ARB_IDLE: begin
                if (grant_core || grant_dbg) begin
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                state_nxt = ARB_IDLE;
                if (owner == OWN_CORE) begin
                    core_resp_valid = 1'b1;
                    core_resp_data  = op_we ? '0 : mem_rdata;
                end else begin
                    dbg_resp_valid = 1'b1;
                    dbg_resp_data  = op_we ? '0 : mem_rdata;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Memory request registers; mem_we lasts only for the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            op_we     <= 1'b0;
            owner     <= OWN_CORE;
        end else if (grant_dbg) begin
            mem_addr  <= dbg_req_addr;
            mem_wdata <= dbg_req_wdata;
            mem_we    <= dbg_req_we;
            op_we     <= dbg_req_we;
            owner     <= OWN_DBG;
        end else if (grant_core) begin
            mem_addr  <= core_req_addr;
            mem_wdata <= core_req_wdata;
            mem_we    <= core_req_we;
            op_we     <= core_req_we;
            owner     <= OWN_CORE;
        end else if (state == ARB_ISSUE) begin
            mem_we <= 1'b0;
        end
    end

`ifdef SODOR_ARB_PERF_EN
    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_core_grants <= '0;
            perf_dbg_grants  <= '0;
            perf_core_stall  <= '0;
        end else begin
            if (grant_core) begin
                perf_core_grants <= perf_core_grants + 32'd1;
            end
            if (grant_dbg) begin
                perf_dbg_grants <= perf_dbg_grants + 32'd1;
            end
            if (core_req_valid && !core_req_ready) begin
                perf_core_stall <= perf_core_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sodor_dmem_arbiter.sv
// Scoreboard bench for sodor_dmem_arbiter; responses are checked by a
// monitor against expectations queued at request acceptance.
module tb_sodor_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req_valid = 1'b0;
    logic        core_req_ready;
    logic [31:0] core_req_addr = '0;
    logic [31:0] core_req_wdata = '0;
    logic        core_req_we = 1'b0;
    logic        core_resp_valid;
    logic [31:0] core_resp_data;
    logic        dbg_req_valid = 1'b0;
    logic        dbg_req_ready;
    logic [31:0] dbg_req_addr = '0;
    logic [31:0] dbg_req_wdata = '0;
    logic        dbg_req_we = 1'b0;
    logic        dbg_resp_valid;
    logic [31:0] dbg_resp_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata = '0;
`ifdef SODOR_ARB_PERF_EN
    logic [31:0] perf_core_grants;
    logic [31:0] perf_dbg_grants;
    logic [31:0] perf_core_stall;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;

    sb_t         core_q[$];
    sb_t         dbg_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    sodor_dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MAX_STREAK (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_req_valid  (core_req_valid),
        .core_req_ready  (core_req_ready),
        .core_req_addr   (core_req_addr),
        .core_req_wdata  (core_req_wdata),
        .core_req_we     (core_req_we),
        .core_resp_valid (core_resp_valid),
        .core_resp_data  (core_resp_data),
        .dbg_req_valid   (dbg_req_valid),
        .dbg_req_ready   (dbg_req_ready),
        .dbg_req_addr    (dbg_req_addr),
        .dbg_req_wdata   (dbg_req_wdata),
        .dbg_req_we      (dbg_req_we),
        .dbg_resp_valid  (dbg_resp_valid),
        .dbg_resp_data   (dbg_resp_data),
`ifdef SODOR_ARB_PERF_EN
        .perf_core_grants(perf_core_grants),
        .perf_dbg_grants (perf_dbg_grants),
        .perf_core_stall (perf_core_stall),
`endif
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: samples on the edge, read data valid the next cycle.
    always @(posedge clk) begin
        mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        sb_t e;
        if (core_resp_valid && dbg_resp_valid) begin
            checks++;
            errors++;
            $display("FAIL resp_exclusive: both resp_valid high, required at most one");
        end
        if (core_resp_valid) begin
            if (core_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL core_unexpected_resp: got resp data 0x%08h, required no response", core_resp_data);
            end else begin
                e = core_q.pop_front();
                chk("core_resp_data", core_resp_data, e.data);
                chk("core_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (dbg_resp_valid) begin
            if (dbg_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dbg_unexpected_resp: got resp data 0x%08h, required no response", dbg_resp_data);
            end else begin
                e = dbg_q.pop_front();
                chk("dbg_resp_data", dbg_resp_data, e.data);
                chk("dbg_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push_exp(input bit use_dbg, input logic [31:0] data);
        sb_t e;
        e.data = data;
        e.cyc  = cyc + 2;
        if (use_dbg) dbg_q.push_back(e);
        else         core_q.push_back(e);
    endtask

    // Single access with ISSUE/RESP phase checks on the memory port.
    task automatic issue(input bit use_dbg, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [31:0] exp, output int waited);
        @(posedge clk); #1;
        if (use_dbg) begin
            dbg_req_valid = 1'b1; dbg_req_addr = addr; dbg_req_wdata = wdata; dbg_req_we = we;
        end else begin
            core_req_valid = 1'b1; core_req_addr = addr; core_req_wdata = wdata; core_req_we = we;
        end
        waited = 0;
        forever begin
            @(negedge clk);
            if (use_dbg ? dbg_req_ready : core_req_ready) break;
            waited++;
            if (waited > 20) break;
        end
        if (waited > 20) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ready not seen in 20 cycles, required handshake");
            core_req_valid = 1'b0;
            dbg_req_valid  = 1'b0;
            return;
        end
        push_exp(use_dbg, exp);
        chk("mem_we_accept_cycle", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
        @(negedge clk);
        chk("issue_mem_we", {31'b0, mem_we}, {31'b0, we});
        chk("issue_mem_addr", mem_addr, addr);
        if (we) chk("issue_mem_wdata", mem_wdata, wdata);
        chk("issue_readies", {30'b0, core_req_ready, dbg_req_ready}, 32'd0);
        @(negedge clk);
        chk("resp_mem_we", {31'b0, mem_we}, 32'd0);
        chk("resp_readies", {30'b0, core_req_ready, dbg_req_ready}, 32'd0);
    endtask

    initial begin
        int          w;
        int          ngrant;
        int          budget;
        int          last;
        bit          drop_core;
        logic [47:0] ord;
        logic [47:0] exp_ord;

        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h200] = 32'hC0DE0200;
        mem[32'h300] = 32'hDB600300;

        repeat (3) @(negedge clk);
        chk("reset_mem_we", {31'b0, mem_we}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_resp", {30'b0, core_resp_valid, dbg_resp_valid}, 32'd0);
        chk("reset_resp_data", core_resp_data | dbg_resp_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_readies", {30'b0, core_req_ready, dbg_req_ready}, 32'd0);

        // Core read alone, debug write, debug read-back.
        issue(1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, w);
        chk("core_read_immediate_ready", 32'(w), 32'd0);
        issue(1'b1, 32'h40, 32'h12345678, 1'b1, 32'h0, w);
        issue(1'b1, 32'h40, 32'h0, 1'b0, 32'h12345678, w);

        // Both requesters held valid: streak limit lets the core in 5th.
        @(posedge clk); #1;
        core_req_valid = 1'b1; core_req_addr = 32'h200; core_req_we = 1'b0;
        dbg_req_valid  = 1'b1; dbg_req_addr  = 32'h300; dbg_req_we  = 1'b0;
        ngrant = 0; budget = 60; ord = '0;
        while (ngrant < 6 && budget > 0) begin
            budget--;
            drop_core = 1'b0;
            @(negedge clk);
            if (core_req_ready && dbg_req_ready) begin
                checks++; errors++;
                $display("FAIL arb_both_ready: both readies high, required one");
            end
            if (core_req_ready) begin
                ord = {ord[39:0], "C"}; ngrant++; drop_core = 1'b1;
                push_exp(1'b0, 32'hC0DE0200);
            end else if (dbg_req_ready) begin
                ord = {ord[39:0], "D"}; ngrant++;
                push_exp(1'b1, 32'hDB600300);
            end
            @(posedge clk); #1;
            if (drop_core) core_req_valid = 1'b0;
            if (ngrant == 6) dbg_req_valid = 1'b0;
        end
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
        exp_ord = "DDDDCD";
        checks++;
        if (ord !== exp_ord) begin
            errors++;
            $display("FAIL arb_order: got %s required %s", ord, exp_ord);
        end
        repeat (4) @(negedge clk);

        // Reset while a write is in ISSUE.
        @(posedge clk); #1;
        core_req_valid = 1'b1; core_req_addr = 32'h500; core_req_wdata = 32'hAAAA5555; core_req_we = 1'b1;
        @(negedge clk);
        chk("rst_test_ready", {31'b0, core_req_ready}, 32'd1);
        @(posedge clk); #1;
        core_req_valid = 1'b0;
        chk("rst_test_issue_we", {31'b0, mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_async_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_quiet", {28'b0, core_req_ready, dbg_req_ready, core_resp_valid, mem_we}, 32'd0);
        issue(1'b0, 32'h500, 32'h0, 1'b0, 32'h0, w);
        chk("post_reset_immediate_ready", 32'(w), 32'd0);
        issue(1'b0, 32'h500, 32'h0BADF00D, 1'b1, 32'h0, w);
        issue(1'b0, 32'h500, 32'h0, 1'b0, 32'h0BADF00D, w);

        // Fresh reset, then back-to-back core requests held valid.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        core_req_valid = 1'b1; core_req_addr = 32'h100; core_req_we = 1'b0;
        ngrant = 0; budget = 30; last = -1;
        while (ngrant < 3 && budget > 0) begin
            budget--;
            @(negedge clk);
            if (dbg_req_ready) begin
                checks++; errors++;
                $display("FAIL b2b_dbg_ready: dbg ready high with no dbg request");
            end
            if (core_req_ready) begin
                push_exp(1'b0, 32'hDEADBEEF);
                if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                ngrant++;
            end
        end
        if (ngrant < 3) begin
            checks++; errors++;
            $display("FAIL b2b_timeout: got %0d grants required 3", ngrant);
        end
        repeat (3) @(posedge clk);
        #1 core_req_valid = 1'b0;
        repeat (4) @(negedge clk);
`ifdef SODOR_ARB_PERF_EN
        chk("perf_core_grants", perf_core_grants, 32'd3);
        chk("perf_core_stall", perf_core_stall, 32'd6);
        chk("perf_dbg_grants", perf_dbg_grants, 32'd0);
`endif

        chk("core_q_drained", 32'(core_q.size()), 32'd0);
        chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sodor_dmem_arbiter.md
Name: sodor_dmem_arbiter

Overview:
- Shares the single data-memory port of the sodor memory model between two requesters: the core data port (core_*) and the debug/loader port (dbg_*).
- Uses a valid/ready request handshake per requester and a one-cycle response strobe.
- Sequences each access through IDLE→ISSUE→RESP so that the memory's write-enable is high for exactly one sampling edge.
- Sits between the core/debug module and the memory model's dmem_req_*/dmem_resp_data pins.

Parameters:
- ADDR_W, 32, address width (matches SIZE_OF_THE_BUS)
- DATA_W, 32, data width
- MAX_STREAK, 4, maximum consecutive debug grants while a core request is pending (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- core_req_valid  in  1  core request present
- core_req_ready  out  1  core request accepted this cycle
- core_req_addr  in  ADDR_W  byte address
- core_req_wdata  in  DATA_W  write data
- core_req_we  in  1  1=write, 0=read
- core_resp_valid  out  1  one-cycle response strobe
- core_resp_data  out  DATA_W  read data; 0 for writes
- dbg_req_valid, dbg_req_ready, dbg_req_addr, dbg_req_wdata, dbg_req_we, dbg_resp_valid, dbg_resp_data  same as core_*
- mem_addr  out  ADDR_W  to dmem_req_addr
- mem_wdata  out  DATA_W  to dmem_req_data
- mem_we  out  1  to dmem_req_write_en
- mem_rdata  in  DATA_W  from dmem_resp_data; valid the cycle after the sampling edge

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All ready/resp_valid outputs = 0; mem_addr, mem_wdata, mem_we = 0; resp_data = 0.
  - streak=0; owner=CORE.
  - Reset during ISSUE drops mem_we to 0 at once. The in-flight access is lost and no response is issued.
- Handshake: a request transfers when valid && ready.
  - ready is combinational and asserted only in IDLE, for the granted requester.
  - A requester holds valid and its payload stable until ready.
- Arbitration in IDLE:
  - Debug has priority.
  - If core_req_valid && dbg_req_valid && streak==MAX_STREAK, grant the core.
  - Otherwise grant debug if dbg_req_valid, else core if core_req_valid.
  - Neither valid: no grant; state stays IDLE.
- Streak counter:
  - +1 on each debug grant while core_req_valid=1 (saturating at MAX_STREAK).
  - Cleared on any core grant, or on a debug grant while core_req_valid=0.
- FSM:
  - IDLE→ISSUE on grant. The edge latches addr, wdata, we into mem_addr, mem_wdata, mem_we and records the owner.
  - ISSUE→RESP unconditionally; the memory samples at the end of ISSUE. mem_we returns to 0 on that edge.
  - RESP→IDLE unconditionally. In RESP the owner's resp_valid=1.
  - resp_data is driven combinationally: mem_rdata for reads, 0 for writes. The non-owner's resp_valid=0.
- Latency: request accepted in cycle N → resp_valid in cycle N+2. Maximum throughput is one access per 3 cycles.
- mem_addr and mem_wdata hold their last values outside ISSUE. Harmless idle reads occur.
- No request is accepted in ISSUE or RESP: both ready=0.
- Address is passed through unmodified (word indexing is done in memory).

Optional Feature:
- Macro: SODOR_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_core_grants[31:0], perf_dbg_grants[31:0], perf_core_stall[31:0].
  - perf_core_stall counts cycles with core_req_valid && !core_req_ready.
  - All three wrap modulo 2^32 and clear on reset.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sodor_arb_pkg:
  - state enum {ARB_IDLE, ARB_ISSUE, ARB_RESP}.
  - owner enum {OWN_CORE, OWN_DBG}.
  - Width localparams defaulting to 32.
- One sub-module, sodor_arb_grant:
  - Combinational priority and streak decision.
  - Plus the streak register.
  - Outputs grant_core and grant_dbg.

Test Plan:
- Core read addr 0x100 alone, mem_rdata=0xDEADBEEF in RESP → core_req_ready in cycle 0, mem_we=0 in cycle 1, core_resp_valid and data=0xDEADBEEF in cycle 2.
- Dbg write addr 0x40, data 0x12345678 → mem_we=1 for exactly one cycle (ISSUE) with mem_addr=0x40 and mem_wdata=0x12345678; dbg_resp_valid=1 and data=0 in cycle 2.
- Both valid in the same cycle, MAX_STREAK=4, dbg continuously valid → grant order D,D,D,D,C,D…; the core is served on its 5th arbitration.
- Back-to-back core requests held valid → ready pulses every 3 cycles, never in ISSUE or RESP.
- rst_n low mid-ISSUE of a write → mem_we=0 immediately, no resp_valid, state IDLE after release; the next request completes normally.
- SODOR_ARB_PERF_EN defined, 3 core grants with 6 stall cycles → perf_core_grants=3, perf_core_stall=6, perf_dbg_grants=0.
